// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit beside the EX stage.
// Handles MULT, MULTU, DIV, DIVU (radix-2 shift-add / restoring divide, one
// step per cycle) and MTHI/MTLO (single-edge writes). busy is the stall
// request towards the hazard unit; done pulses in the cycle the new HI/LO
// values become visible.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies skip the iteration
// phase and form the product combinationally in FIX (1-cycle busy).
// Divide timing and all results are identical with or without the macro.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 32'sd1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef MULDIV_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
`else
    localparam logic FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Absolute value of a signed operand; unsigned operands pass through.
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CW-1:0]      cnt_r;

    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div0_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    // acc_hi_r: partial product (mul, bit WIDTH is the add carry) or
    // partial remainder (div). acc_lo_r: multiplier being consumed LSB
    // first (mul) or dividend shifting out / quotient shifting in (div).
    logic [WIDTH:0]     acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;

    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               launch_s;
    logic               mthi_we_s;
    logic               mtlo_we_s;
    logic               step_s;
    logic               commit_s;
    logic               op_div_s;
    logic               op_signed_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH:0]     step_hi_s;
    logic [WIDTH-1:0]   step_lo_s;

    logic [2*WIDTH-1:0] mul_raw_s;
    logic [2*WIDTH-1:0] mul_fix_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    assign busy = (state_r != ST_IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Operation class decode used when capturing operands.
    always_comb begin
        op_div_s    = 1'b0;
        op_signed_s = 1'b0;
        case (op)
            OP_MULT: begin
                op_div_s    = 1'b0;
                op_signed_s = 1'b1;
            end
            OP_DIV: begin
                op_div_s    = 1'b1;
                op_signed_s = 1'b1;
            end
            OP_DIVU: begin
                op_div_s    = 1'b1;
                op_signed_s = 1'b0;
            end
            default: begin
                op_div_s    = 1'b0;
                op_signed_s = 1'b0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and control decode; flush always wins over start.
    always_comb begin
        state_nx_s = state_r;
        launch_s   = 1'b0;
        mthi_we_s  = 1'b0;
        mtlo_we_s  = 1'b0;
        step_s     = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            launch_s   = 1'b1;
                            state_nx_s = FAST_MUL ? ST_FIX : ST_ITER;
                        end
                        OP_DIV, OP_DIVU: begin
                            launch_s   = 1'b1;
                            state_nx_s = ST_ITER;
                        end
                        OP_MTHI: begin
                            mthi_we_s  = 1'b1;
                            state_nx_s = ST_IDLE;
                        end
                        OP_MTLO: begin
                            mtlo_we_s  = 1'b1;
                            state_nx_s = ST_IDLE;
                        end
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (flush) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        state_nx_s = ST_FIX;
                    end else begin
                        state_nx_s = ST_ITER;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    commit_s = 1'b0;
                end else begin
                    commit_s = 1'b1;
                end
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s   = {(WIDTH+1){1'b0}};
        div_shift_s = {(WIDTH+1){1'b0}};
        div_trial_s = {(WIDTH+1){1'b0}};
        step_hi_s   = acc_hi_r;
        step_lo_s   = acc_lo_r;
        if (is_div_r) begin
            div_shift_s = {acc_hi_r[WIDTH-1:0], acc_lo_r[WIDTH-1]};
            div_trial_s = div_shift_s - {1'b0, mag_b_r};
            if (!div_trial_s[WIDTH]) begin
                step_hi_s = div_trial_s;
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s;
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            mul_sum_s = acc_hi_r + (acc_lo_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
            step_hi_s = {1'b0, mul_sum_s[WIDTH:1]};
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Operand capture at launch, then one iteration per ITER cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_ZERO;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
            a_raw_r  <= {WIDTH{1'b0}};
            mag_a_r  <= {WIDTH{1'b0}};
            mag_b_r  <= {WIDTH{1'b0}};
            acc_hi_r <= {(WIDTH+1){1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
        end else if (launch_s) begin
            cnt_r    <= CNT_ZERO;
            is_div_r <= op_div_s;
            neg_q_r  <= op_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r  <= op_signed_s & op_div_s & a[WIDTH-1];
            div0_r   <= op_div_s & (b == {WIDTH{1'b0}});
            a_raw_r  <= a;
            mag_a_r  <= magnitude(a, op_signed_s);
            mag_b_r  <= magnitude(b, op_signed_s);
            acc_hi_r <= {(WIDTH+1){1'b0}};
            acc_lo_r <= op_div_s ? magnitude(a, op_signed_s) : magnitude(b, op_signed_s);
        end else if (step_s) begin
            cnt_r    <= cnt_r + CNT_ONE;
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign mul_raw_s = {{WIDTH{1'b0}}, mag_a_r} * {{WIDTH{1'b0}}, mag_b_r};
`else
    assign mul_raw_s = {acc_hi_r[WIDTH-1:0], acc_lo_r};
`endif

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        mul_fix_s = mul_raw_s;
        res_hi_s  = {WIDTH{1'b0}};
        res_lo_s  = {WIDTH{1'b0}};
        if (is_div_r) begin
            if (div0_r) begin
                res_hi_s = a_raw_r;
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = neg_q_r ? -acc_lo_r : acc_lo_r;
                res_hi_s = neg_r_r ? -acc_hi_r[WIDTH-1:0] : acc_hi_r[WIDTH-1:0];
            end
        end else begin
            mul_fix_s = neg_q_r ? -mul_raw_s : mul_raw_s;
            res_hi_s  = mul_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s  = mul_fix_s[WIDTH-1:0];
        end
    end

    // Architectural HI/LO registers and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= commit_s;
            if (commit_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else if (mthi_we_s) begin
                hi_r <= a;
            end else if (mtlo_we_s) begin
                lo_r <= a;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the EX stage. It is the stall-requesting end of the hazard interface: `busy` tells the hazard/forwarding logic to hold IF/ID and bubble ID/EX while an MFHI/MFLO or a new mul/div op is waiting.
- `hi` and `lo` are architectural registers and are read directly by the EX-stage MFHI/MFLO mux.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- ITER, 32: iteration count for shift-add multiply and restoring divide; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  issue strobe from EX; sampled on a rising edge.
- op  input  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
- a  input  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO data).
- b  input  WIDTH  rt operand (divisor, multiplier).
- flush  input  1  cancel the in-flight op (branch/exception flush of EX).
- busy  output  1  unit is occupied; stall request to the hazard unit.
- done  output  1  one-cycle pulse; new HI/LO are visible in this cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset overrides start and flush, and aborts any op mid-flight without writing HI/LO.
- State machine: IDLE, ITER, FIX. `busy` = (state != IDLE), decoded from the registered state. `done` is a registered output.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU: latch magnitudes and sign flags, counter<=0, go to ITER.
  - start=1 with MTHI: hi<=a at the same edge, stay IDLE, done stays 0. MTLO does the same into lo.
  - NOP or reserved op: no effect.
- ITER: one radix-2 step per cycle, counter increments. After ITER steps (counter==ITER-1), go to FIX.
  - Multiply: 2*WIDTH shift-add accumulator.
  - Divide: restoring; remainder WIDTH+1 bits.
- FIX: apply sign correction, write hi/lo, go to IDLE, done<=1 for exactly one cycle.
- Latency: start sampled at edge 0; hi/lo updated at edge ITER+1 (edge 33); busy high for 33 cycles; done high in the cycle after edge 33.
- Signed multiply (MULT): multiply magnitudes; negate the 64-bit product if the signs of a and b differ. {hi,lo}=product.
- MULTU: unsigned product, {hi,lo}=a*b.
- Signed divide (DIV): divide magnitudes.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - lo=quotient, hi=remainder.
- DIVU: lo=a/b, hi=a%b.
- Divide by zero: no exception, full latency. Result is lo=32'hFFFFFFFF and hi=a, for both DIV and DIVU; no sign correction is applied.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0 (two's-complement wrap).
- start while busy: ignored. Not queued, no state change. The hazard unit is responsible for never issuing it.
- flush while busy: next edge state=IDLE, hi/lo unchanged, no done pulse.
- flush and start in the same cycle in IDLE: flush wins; nothing is started and MTHI/MTLO are not written.
- flush in FIX: the write is suppressed.
- Operands a/b are captured at the start edge; later changes on the inputs do not affect the result.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU go from IDLE directly to FIX.
  - The full product is computed combinationally from the latched operands in FIX.
  - hi/lo are written at edge 1 after start; busy is high for 1 cycle; done pulses after edge 1.
  - Divide timing is unchanged.
- Undefined: multiply uses the 32-step ITER path (33-cycle latency).
- Results are identical either way.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). With MULDIV_FAST_MUL_EN: same values, and done occurs 1 cycle after start.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIV, assert flush at cycle 10 -> busy drops next cycle, no done pulse, hi/lo keep prior values. Assert start during busy -> ignored, result matches the original op.
- MTHI a=0xDEADBEEF -> hi=0xDEADBEEF after one edge, busy never rises, done=0. MTLO with flush=1 in the same cycle -> lo unchanged. rst asserted mid-ITER -> hi=lo=0, busy=0 next cycle.
